mm2st_read_dma: RTL
===================

Name: mm2st_read_dma

Overview:
- Read-side DMA that fetches 32-bit words from memory over an Avalon-MM pipelined-read master and emits them on an Avalon-ST source.
- The source feeds the stream processor's Avalon-ST sink; it is the transmitter end of that link.
- Software controls the block through a 4-register Avalon-MM slave CSR using the same conventions as the stream processor: 1-cycle read latency, readdatavalid.
- The data path is raw pass-through with no byte swap. Endianness handling stays in the stream processor.

Parameters:
FIFO_DEPTH, 8, output buffer depth in words (power of 2, at least 2); also bounds in-flight reads
ADDR_W, 32, master byte-address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
avs_address  in  2  CSR word select
avs_write  in  1  CSR write strobe
avs_writedata  in  32  CSR write data
avs_read  in  1  CSR read strobe
avs_readdata  out  32  CSR read data, registered
avs_readdatavalid  out  1  asserted 1 cycle after avs_read
avm_address  out  ADDR_W  master byte address, word aligned
avm_read  out  1  master read request
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  returned read data
avm_readdatavalid  in  1  returned data valid
aso_valid  out  1  stream data valid
aso_data  out  32  stream data
aso_ready  in  1  downstream ready, ready latency 0
irq  out  1  level interrupt, equals done AND ie

Behaviour:
- Reset: every output is 0. CSRs, counters, FIFO and FSM are cleared and the FSM is in IDLE. An asserted reset aborts any transfer immediately; read data still returning after reset is ignored.
- CSR map:
  - 0: SRC_ADDR, R/W.
  - 1: LENGTH in bytes, R/W.
  - 2: CTRL/STATUS. Write: bit0 go, bit1 abort, bit2 ie. Read: bit0 busy, bit1 done, bit2 error, bit3 aborted, bit4 ie.
  - 3: WORDS_SENT, read-only count of accepted aso beats.
- CSR write rules: writes to regs 0 and 1 while busy are ignored. The ie bit is writable at any time. go while busy is ignored.
- CSR read timing: avs_readdatavalid equals avs_read delayed by 1 cycle, and avs_readdata is registered in the same cycle.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE, on go:
  - Clear done, error, aborted and WORDS_SENT.
  - If LENGTH is 0 or LENGTH[1:0] is nonzero: set done, and also set error only for the misaligned case. Issue no reads and stay in IDLE.
  - Otherwise latch addr = SRC_ADDR with its low 2 bits forced to 0, set remaining = LENGTH >> 2, and go to ISSUE.
- ISSUE, credit and issue rules:
  - Assert avm_read only when pending + fifo_count < FIFO_DEPTH. `pending` counts reads accepted by the slave but not yet returned.
  - A read is accepted in a cycle where avm_read is high and avm_waitrequest is low. On acceptance: addr += 4, remaining -= 1, pending += 1.
  - avm_read and avm_address are held stable while avm_waitrequest is high.
  - When remaining reaches 0, go to DRAIN.
- Return path: each avm_readdatavalid pushes avm_readdata into the FIFO and decrements pending. Overflow is impossible by construction. A push and an accept in the same cycle must both take effect.
- Source port:
  - aso_valid = FIFO not empty; aso_data = FIFO head, first-word fall-through.
  - A pop happens on aso_valid AND aso_ready, and increments WORDS_SENT.
  - A simultaneous push and pop is legal, including on a full or empty FIFO.
  - aso_data is held stable while aso_valid is high and aso_ready is low.
- DRAIN: when pending is 0 and the FIFO is empty, set done and go to IDLE.
- Abort: in ISSUE or DRAIN, abort stops new reads at once and goes to FLUSH.
  - A read currently stalled by waitrequest is withdrawn at once.
  - FLUSH sets aso_valid to 0 and clears the FIFO.
  - Returning data is discarded while pending decrements.
  - When pending reaches 0, set aborted and done and go to IDLE.
- Abort in IDLE is a no-op.
- busy is 1 in ISSUE, DRAIN and FLUSH.
- Width rules: remaining is 30 bits. pending and fifo_count are log2(FIFO_DEPTH)+1 bits. addr wraps modulo 2^ADDR_W without error.

Test Plan:
- SRC_ADDR=0x100, LENGTH=16, memory 0x11111111..0x44444444, aso_ready=1 → 4 beats in address order, reads at 0x100/104/108/10C; done=1, WORDS_SENT=4, irq=1 when ie=1.
- LENGTH=64, aso_ready held 0 → exactly 8 reads accepted, then avm_read stays 0; release aso_ready → remaining 8 words arrive in order, no loss or duplicates.
- Random avm_waitrequest and read latency 1–5 cycles, LENGTH=40 → avm_address and avm_read stable during stalls; 10 beats in order.
- go with LENGTH=0 → done=1, error=0, no avm_read; go with LENGTH=6 → done=1, error=1, no avm_read.
- LENGTH=256, abort after 5 beats with 3 reads pending → FLUSH, aso_valid=0 afterwards, returned data discarded, done=1, aborted=1, WORDS_SENT=5.
- reset_n asserted mid-transfer → all outputs 0 within the same cycle; the next go runs a clean 16-byte transfer.

Source files
------------

// File: rtl/mm2st_read_dma_if.sv
// Bus bundle for the read DMA: CSR slave, pipelined-read master and stream source.
interface mm2st_read_dma_if #(
   parameter int ADDR_W = 32
);
   logic [1:0]        avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [31:0]       avm_readdata;
   logic              avm_readdatavalid;
   logic              aso_valid;
   logic [31:0]       aso_data;
   logic              aso_ready;
   logic              irq;

   // DMA side
   modport master (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata, avs_readdatavalid,
      output avm_address, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output aso_valid, aso_data,
      input  aso_ready,
      output irq
   );

   // Environment side: CPU, memory and stream sink
   modport slave (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata, avs_readdatavalid,
      input  avm_address, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  aso_valid, aso_data,
      output aso_ready,
      input  irq
   );
endinterface

// File: rtl/mm2st_read_dma.sv
// Memory-to-stream read DMA: credit-limited Avalon-MM pipelined reads feeding a
// first-word fall-through buffer that drives an Avalon-ST source.
module mm2st_read_dma #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   mm2st_read_dma_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;
   state_t state_reg, state_next;

   logic [31:0]       src_addr_reg, length_reg, words_sent_reg, rdata_reg;
   logic              ie_reg, done_reg, error_reg, aborted_reg, rvalid_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [29:0]       remaining_reg;
   logic [CW-1:0]     pending_reg, fifo_count_reg;
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [31:0]       slot_q [FIFO_DEPTH];

   logic ctrl_wr, go_cmd, abort_cmd, len_ok, credit_ok;
   logic accept, ret, push, pop;
   logic start, start_bad, finish_ok, finish_abort, flush_fifo, busy, avm_read_c;

   assign ctrl_wr   = bus.avs_write && (bus.avs_address == 2'd2);
   assign go_cmd    = ctrl_wr && bus.avs_writedata[0];
   assign abort_cmd = ctrl_wr && bus.avs_writedata[1];
   assign len_ok    = (length_reg != 32'd0) && (length_reg[1:0] == 2'b00);
   // Buffer space is reserved for every outstanding read, so returns never overflow.
   assign credit_ok = ({1'b0, pending_reg} + {1'b0, fifo_count_reg}) < DEPTH_C;
   assign accept    = bus.avm_read && !bus.avm_waitrequest;
   // Returns with nothing outstanding (e.g. after a reset) are stale and ignored.
   assign ret       = bus.avm_readdatavalid && (pending_reg != '0);
   assign push      = ret && ((state_reg == ISSUE) || (state_reg == DRAIN));
   assign pop       = bus.aso_valid && bus.aso_ready;
   assign start_bad = start && !len_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (go_cmd && len_ok) state_next = ISSUE;
         ISSUE:   if (abort_cmd) state_next = FLUSH;
                  else if (accept && (remaining_reg == 30'd1)) state_next = DRAIN;
         DRAIN:   if (abort_cmd) state_next = FLUSH;
                  else if ((pending_reg == '0) && (fifo_count_reg == '0)) state_next = IDLE;
         FLUSH:   if (pending_reg == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      avm_read_c   = 1'b0;
      start        = 1'b0;
      finish_ok    = 1'b0;
      finish_abort = 1'b0;
      flush_fifo   = 1'b0;
      busy         = 1'b1;
      case (state_reg)
         IDLE: begin
            busy  = 1'b0;
            start = go_cmd;
         end
         ISSUE: begin
            // An abort withdraws the request in the same cycle, even mid-stall.
            avm_read_c = credit_ok && !abort_cmd;
            flush_fifo = abort_cmd;
         end
         DRAIN: begin
            flush_fifo = abort_cmd;
            finish_ok  = !abort_cmd && (pending_reg == '0) && (fifo_count_reg == '0);
         end
         FLUSH:   finish_abort = (pending_reg == '0);
         default: busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_addr_reg   <= '0;
         length_reg     <= '0;
         ie_reg         <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         aborted_reg    <= 1'b0;
         words_sent_reg <= '0;
         addr_reg       <= '0;
         remaining_reg  <= '0;
         pending_reg    <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         rdata_reg      <= '0;
         rvalid_reg     <= 1'b0;
      end else begin
         if (bus.avs_write && !busy) begin
            if (bus.avs_address == 2'd0) src_addr_reg <= bus.avs_writedata;
            if (bus.avs_address == 2'd1) length_reg   <= bus.avs_writedata;
         end
         if (ctrl_wr) ie_reg <= bus.avs_writedata[2];

         if (start) begin
            done_reg    <= start_bad;
            error_reg   <= start_bad && (length_reg[1:0] != 2'b00);
            aborted_reg <= 1'b0;
         end else begin
            if (finish_ok || finish_abort) done_reg <= 1'b1;
            if (finish_abort) aborted_reg <= 1'b1;
         end

         if (start)    words_sent_reg <= '0;
         else if (pop) words_sent_reg <= words_sent_reg + 32'd1;

         if (start && len_ok) begin
            addr_reg      <= {src_addr_reg[ADDR_W-1:2], 2'b00};
            remaining_reg <= length_reg[31:2];
         end else if (accept) begin
            addr_reg      <= addr_reg + ADDR_W'(4);
            remaining_reg <= remaining_reg - 30'd1;
         end

         pending_reg <= pending_reg + CW'(accept) - CW'(ret);

         if (flush_fifo) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            fifo_count_reg <= fifo_count_reg + CW'(push) - CW'(pop);
         end

         rvalid_reg <= bus.avs_read;
         if (bus.avs_read) begin
            case (bus.avs_address)
               2'd0:    rdata_reg <= src_addr_reg;
               2'd1:    rdata_reg <= length_reg;
               2'd2:    rdata_reg <= {27'd0, ie_reg, aborted_reg, error_reg, done_reg, busy};
               default: rdata_reg <= words_sent_reg;
            endcase
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi = gi + 1) begin : g_slot
         logic [31:0] data_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                                data_reg <= '0;
            else if (push && (wr_ptr_reg == PW'(gi)))    data_reg <= bus.avm_readdata;
         end
         assign slot_q[gi] = data_reg;
      end
   endgenerate

   assign bus.avm_read          = avm_read_c;
   assign bus.avm_address       = addr_reg;
   assign bus.aso_valid         = (fifo_count_reg != '0);
   assign bus.aso_data          = slot_q[rd_ptr_reg];
   assign bus.avs_readdata      = rdata_reg;
   assign bus.avs_readdatavalid = rvalid_reg;
   assign bus.irq               = done_reg & ie_reg;
endmodule
